shift_add_datapath: RTL and testbench
=====================================

SHIFT_ADD_DATAPATH -- requirements
Module: shift_add_datapath

Interface
REQ-001 Parameter N, default 4: operand width in bits; the product width is 2N.
REQ-002 Clk  input  1  System clock; all state updates on the rising edge.
REQ-003 Rstn  input  1  Reset, synchronous, active-low.
REQ-004 Load  input  1  From controller: load operands, clear the accumulator, clear the bit counter.
REQ-005 Sh  input  1  From controller: shift the accumulator right by one and increment the bit counter.
REQ-006 Ad  input  1  From controller: add the multiplicand into the accumulator upper half.
REQ-007 Done  input  1  From controller: multiplication complete; capture the product.
REQ-008 Mplier  input  N  Multiplier operand, sampled only on Load.
REQ-009 Mcand  input  N  Multiplicand operand, sampled only on Load into an internal N-bit register.
REQ-010 M  output  1  To controller: current multiplier LSB, equal to ACC[0], combinational from the register.
REQ-011 K  output  1  To controller: last bit, high when counter == N-1, combinational from the register.
REQ-012 Product  output  2N  Multiplication result.
REQ-013 Valid  output  1  One-cycle pulse the cycle after Done is sampled.

Function
REQ-014 The SHALL statements below define the datapath state: a (2N+1)-bit accumulator ACC, an N-bit multiplicand register MC, and a ceil(log2 N)-bit counter CNT.
REQ-015 On Load, the block SHALL set ACC[2N:N]=0, ACC[N-1:0]=Mplier, MC=Mcand and CNT=0.
REQ-016 On Ad alone, ACC[2N:N] SHALL become ACC[2N-1:N]+MC, zero-extended to N+1 bits with the carry captured in ACC[2N], and ACC[N-1:0] SHALL remain unchanged.
REQ-017 On Sh alone, ACC SHALL become {1'b0, ACC[2N:1]} and CNT SHALL become CNT+1.
REQ-018 On Ad and Sh together, the block SHALL shift the post-add value right by one in the same cycle and SHALL increment CNT.
REQ-019 Priority SHALL be Load over Ad/Sh; when Load is asserted, Ad and Sh are ignored.
REQ-020 CNT SHALL wrap from N-1 to 0 on Sh; K SHALL not stay high after a wrap.
REQ-021 When no control input is asserted, ACC, MC and CNT SHALL hold.
REQ-022 After N shifts, ACC[2N-1:0] SHALL equal Mplier*Mcand (unsigned) and ACC[2N] SHALL be 0.
REQ-023 On Done, Valid SHALL pulse high for exactly one cycle; Done held high for several cycles SHALL produce one pulse per cycle.
REQ-024 Done asserted together with Load SHALL capture the pre-load ACC, because Load takes effect on the same edge.
REQ-025 The Mplier and Mcand inputs SHALL have no effect outside Load cycles.

Reset
REQ-026 With Rstn low at a rising edge, ACC, MC, CNT, Valid and the Product register SHALL clear to 0, so that M=0, K=0 (for N>1) and Product=0.
REQ-027 Reset SHALL override Load, Ad, Sh and Done in the same cycle, including reset in mid-operation.
REQ-028 After reset, a new Load SHALL start a correct multiplication with no residue from the aborted operation.

Configuration
REQ-029 Macro PRODUCT_REG_EN SHALL select the Product output path.
REQ-030 With PRODUCT_REG_EN defined, Product SHALL be a 2N-bit register loaded from ACC[2N-1:0] when Done is sampled, and SHALL hold until the next Done or reset.
REQ-031 Without PRODUCT_REG_EN, Product SHALL be combinational ACC[2N-1:0], with no Product register; Valid behaviour SHALL be unchanged.

Verification
REQ-032 N=4: Load with Mplier=4'hB, Mcand=4'hD, then the controller sequence (Ad when M, then Sh) for 4 bits, then Done -> Product=8'h8F, Valid pulses one cycle; K is high only during the 4th bit.
REQ-033 N=4: Mplier=4'hF, Mcand=4'hF -> the carry appears in ACC[8] after adds and Product=8'hE1; Mplier=0 -> M never high, Product=8'h00.
REQ-034 Load with Mplier=4'h1, Mcand=4'h3, then assert Ad and Sh together in one cycle -> ACC={1'b0,4'h3,4'h1}>>1 = 9'h018 and CNT=1.
REQ-035 Rstn low after 2 shifts of an operation -> next edge ACC=0, CNT=0, K=0, M=0; a subsequent 4'h6*4'h7 run yields 8'h2A.
REQ-036 Four Sh pulses with no Load -> CNT sequence 1,2,3,0 and K high only while CNT=3; then Done with Load in the same cycle -> Product equals the pre-load ACC[7:0] (macro defined).

Source files
------------

// File: rtl/shift_add_datapath.sv
// Shift-and-add multiplier datapath: accumulator, multiplicand register and bit counter.
// Build option: define PRODUCT_REG_EN for a Product register captured on Done.
module shift_add_datapath #(
    parameter int N = 4
) (
    input  logic           Clk,
    input  logic           Rstn,
    input  logic           Load,
    input  logic           Sh,
    input  logic           Ad,
    input  logic           Done,
    input  logic [N-1:0]   Mplier,
    input  logic [N-1:0]   Mcand,
    output logic           M,
    output logic           K,
    output logic [2*N-1:0] Product,
    output logic           Valid
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [2*N:0]  acc_q, acc_d;
    logic [N-1:0]  mc_q, mc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q;
    logic [2*N:0]  sum;

    always_comb begin
        acc_d = acc_q;
        mc_d  = mc_q;
        cnt_d = cnt_q;
        sum   = acc_q;
        // The add feeds the shifter so Ad and Sh together complete a bit in one cycle.
        if (Ad) begin
            sum[2*N:N] = {1'b0, acc_q[2*N-1:N]} + {1'b0, mc_q};
        end
        if (Load) begin
            acc_d = {{(N+1){1'b0}}, Mplier};
            mc_d  = Mcand;
            cnt_d = '0;
        end else begin
            acc_d = sum;
            if (Sh) begin
                acc_d = {1'b0, sum[2*N:1]};
                cnt_d = (cnt_q == CW'(N-1)) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            acc_q   <= '0;
            mc_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            cnt_q   <= cnt_d;
            valid_q <= Done;
        end
    end

    assign M     = acc_q[0];
    assign K     = (cnt_q == CW'(N-1));
    assign Valid = valid_q;

`ifdef PRODUCT_REG_EN
    logic [2*N-1:0] prod_q;

    // Samples the pre-edge accumulator, so Done with Load captures the old result.
    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            prod_q <= '0;
        end else if (Done) begin
            prod_q <= acc_q[2*N-1:0];
        end
    end

    assign Product = prod_q;
`else
    assign Product = acc_q[2*N-1:0];
`endif

endmodule

// File: tb/tb_shift_add_datapath.sv
// Randomized self-checking bench for shift_add_datapath (N=4) against an arithmetic model.
module tb_shift_add_datapath;
    localparam int N = 4;

    logic       Clk = 1'b0;
    logic       Rstn, Load, Sh, Ad, Done;
    logic [3:0] Mplier, Mcand;
    logic       M, K, Valid;
    logic [7:0] Product;

    int checks = 0;
    int failures = 0;

    int unsigned m_acc, m_mc, m_cnt, m_prod;
    logic        m_valid;

    shift_add_datapath #(.N(N)) dut (
        .Clk(Clk), .Rstn(Rstn), .Load(Load), .Sh(Sh), .Ad(Ad), .Done(Done),
        .Mplier(Mplier), .Mcand(Mcand), .M(M), .K(K), .Product(Product), .Valid(Valid)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] exp_product();
        logic [7:0] p;
`ifdef PRODUCT_REG_EN
        p = m_prod[7:0];
`else
        p = m_acc[7:0];
`endif
        return p;
    endfunction

    // One clock with the given controls; the model advances from the pre-edge state.
    task automatic cyc(input logic rn, ld, sh, ad, dn, input logic [3:0] mp, mc);
        Rstn = rn; Load = ld; Sh = sh; Ad = ad; Done = dn; Mplier = mp; Mcand = mc;
        @(posedge Clk);
        if (!rn) begin
            m_acc = 0; m_mc = 0; m_cnt = 0; m_prod = 0; m_valid = 1'b0;
        end else begin
            if (dn) m_prod = m_acc % 256;
            m_valid = dn;
            if (ld) begin
                m_acc = mp; m_mc = mc; m_cnt = 0;
            end else begin
                if (ad) m_acc = (m_acc % 256) + m_mc * 16;
                if (sh) begin
                    m_acc = m_acc / 2;
                    m_cnt = (m_cnt + 1) % N;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b0, 0, 0, 0, 0, 4'h0, 4'h0);
        cyc(1'b1, 1, 0, 0, 0, 4'hF, 4'hF);
        cyc(1'b1, 0, 1, 1, 1, 4'h0, 4'h0);
        cyc(1'b0, 1, 1, 1, 1, 4'hF, 4'hF);
        checks += 4;
        if (M !== 1'b0)      begin failures++; $display("FAIL reset_M got=%b exp=0", M); end
        if (K !== 1'b0)      begin failures++; $display("FAIL reset_K got=%b exp=0", K); end
        if (Product !== 8'h0) begin failures++; $display("FAIL reset_Product got=%h exp=00", Product); end
        if (Valid !== 1'b0)  begin failures++; $display("FAIL reset_Valid got=%b exp=0", Valid); end
    endtask

    task automatic test_known_vectors();
        logic [3:0] a [3] = '{4'hB, 4'hF, 4'h0};
        logic [3:0] b [3] = '{4'hD, 4'hF, 4'h9};
        logic [7:0] p [3] = '{8'h8F, 8'hE1, 8'h00};
        for (int v = 0; v < 3; v++) begin
            int mhigh = 0;
            cyc(1'b1, 1, 0, 0, 0, a[v], b[v]);
            for (int bit_i = 0; bit_i < N; bit_i++) begin
                checks++;
                if (K !== (bit_i == N-1)) begin
                    failures++; $display("FAIL vec_K v=%0d bit=%0d got=%b exp=%b", v, bit_i, K, bit_i == N-1);
                end
                if (M) begin
                    mhigh++;
                    cyc(1'b1, 0, 0, 1, 0, 4'h0, 4'h0);
                end
                cyc(1'b1, 0, 1, 0, 0, 4'h0, 4'h0);
            end
            cyc(1'b1, 0, 0, 0, 1, 4'h0, 4'h0);
            checks += 2;
            if (Product !== p[v]) begin failures++; $display("FAIL vec_Product v=%0d got=%h exp=%h", v, Product, p[v]); end
            if (Valid !== 1'b1)   begin failures++; $display("FAIL vec_Valid v=%0d got=%b exp=1", v, Valid); end
            if (a[v] == 4'h0) begin
                checks++;
                if (mhigh != 0) begin failures++; $display("FAIL vec_M_zero got=%0d exp=0", mhigh); end
            end
            cyc(1'b1, 0, 0, 0, 0, 4'h0, 4'h0);
            checks++;
            if (Valid !== 1'b0) begin failures++; $display("FAIL vec_Valid_pulse v=%0d got=%b exp=0", v, Valid); end
        end
        // Combined Ad+Sh: {0,3,1}>>1 = 9'h018, so M=0 and the low byte is 8'h18.
        cyc(1'b1, 1, 0, 0, 0, 4'h1, 4'h3);
        cyc(1'b1, 0, 1, 1, 0, 4'h0, 4'h0);
        checks += 2;
        if (M !== 1'b0) begin failures++; $display("FAIL adsh_M got=%b exp=0", M); end
        if (m_acc != 32'h18) begin failures++; $display("FAIL adsh_model got=%h exp=018", m_acc); end
        cyc(1'b1, 0, 0, 0, 1, 4'h0, 4'h0);
        checks++;
        if (Product !== 8'h18) begin failures++; $display("FAIL adsh_Product got=%h exp=18", Product); end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1, 0, 0, 0, 4'h6, 4'h7);
        cyc(1'b1, 0, 1, 0, 0, 4'h0, 4'h0);
        cyc(1'b1, 0, 0, 1, 0, 4'h0, 4'h0);
        cyc(1'b1, 0, 1, 0, 1, 4'h0, 4'h0);
        cyc(1'b0, 0, 1, 1, 1, 4'h0, 4'h0);
        checks += 3;
        if (M !== 1'b0)       begin failures++; $display("FAIL midrst_M got=%b exp=0", M); end
        if (K !== 1'b0)       begin failures++; $display("FAIL midrst_K got=%b exp=0", K); end
        if (Product !== 8'h0) begin failures++; $display("FAIL midrst_Product got=%h exp=00", Product); end
        cyc(1'b1, 1, 0, 0, 0, 4'h6, 4'h7);
        for (int bit_i = 0; bit_i < N; bit_i++) begin
            cyc(1'b1, 0, 1, M, 0, 4'h0, 4'h0);
        end
        cyc(1'b1, 0, 0, 0, 1, 4'h0, 4'h0);
        checks++;
        if (Product !== 8'h2A) begin failures++; $display("FAIL midrst_Product6x7 got=%h exp=2a", Product); end
    endtask

    task automatic test_wrap_done_load();
        logic [7:0] pre;
        cyc(1'b1, 1, 0, 0, 0, 4'h9, 4'h5);
        cyc(1'b1, 0, 0, 1, 0, 4'h0, 4'h0);
        for (int s = 1; s <= 4; s++) begin
            cyc(1'b1, 0, 1, 0, 0, 4'h0, 4'h0);
            checks++;
            if (K !== (s == 3)) begin failures++; $display("FAIL wrap_K shift=%0d got=%b exp=%b", s, K, s == 3); end
        end
        pre = m_acc[7:0];
        cyc(1'b1, 1, 0, 0, 1, 4'hA, 4'h3);
        checks += 2;
`ifdef PRODUCT_REG_EN
        if (Product !== pre) begin failures++; $display("FAIL doneload_Product got=%h exp=%h", Product, pre); end
`else
        if (Product !== 8'h0A) begin failures++; $display("FAIL doneload_Product got=%h exp=0a pre=%h", Product, pre); end
`endif
        if (Valid !== 1'b1) begin failures++; $display("FAIL doneload_Valid got=%b exp=1", Valid); end
    endtask

    task automatic test_random_mult();
        for (int t = 0; t < 25; t++) begin
            logic [3:0] a, b;
            logic [7:0] exp;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            exp = a * b;
            cyc(1'b1, 1, 0, 0, 0, a, b);
            for (int bit_i = 0; bit_i < N; bit_i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    cyc(1'b1, 0, 1, M, 0, 4'($urandom), 4'($urandom));
                end else begin
                    if (M) cyc(1'b1, 0, 0, 1, 0, 4'($urandom), 4'($urandom));
                    cyc(1'b1, 0, 1, 0, 0, 4'($urandom), 4'($urandom));
                end
            end
            cyc(1'b1, 0, 0, 0, 1, 4'($urandom), 4'($urandom));
            checks += 2;
            if (Product !== exp) begin failures++; $display("FAIL mult_Product %0d*%0d got=%h exp=%h", a, b, Product, exp); end
            if (Valid !== 1'b1)  begin failures++; $display("FAIL mult_Valid got=%b exp=1", Valid); end
        end
    endtask

    task automatic test_random_ctrl();
        for (int t = 0; t < 400; t++) begin
            cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom));
            checks += 4;
            if (M !== m_acc[0])       begin failures++; $display("FAIL rand_M t=%0d got=%b exp=%b", t, M, m_acc[0]); end
            if (K !== (m_cnt == N-1)) begin failures++; $display("FAIL rand_K t=%0d got=%b exp=%b", t, K, m_cnt == N-1); end
            if (Product !== exp_product()) begin
                failures++; $display("FAIL rand_Product t=%0d got=%h exp=%h", t, Product, exp_product());
            end
            if (Valid !== m_valid) begin failures++; $display("FAIL rand_Valid t=%0d got=%b exp=%b", t, Valid, m_valid); end
        end
    endtask

    initial begin
        Rstn = 1'b0; Load = 1'b0; Sh = 1'b0; Ad = 1'b0; Done = 1'b0; Mplier = '0; Mcand = '0;
        m_acc = 0; m_mc = 0; m_cnt = 0; m_prod = 0; m_valid = 1'b0;
        @(negedge Clk);
        test_reset();
        test_known_vectors();
        test_reset_mid();
        test_wrap_done_load();
        test_random_mult();
        test_random_ctrl();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
